// File: rtl/maxnet_n.sv
// maxnet_n: parametrised Maxnet winner-take-all stage.
//
// Latches N unsigned inputs on start and runs lateral-inhibition updates, one
// per clock, until at most one activation is nonzero or MAX_ITER updates have
// been done. It then reports the winner's original value and index.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (aborts a run, no done pulse)
//   start      in   begin a run; only sampled while idle
//   x_in       in   N packed WIDTH-bit inputs, channel i at [i*WIDTH +: WIDTH]
//   busy       out  high while updates are in progress
//   done       out  one-cycle pulse when the outputs below are valid
//   result     out  original input value of the winner
//   winner_idx out  index of the winner
//   tie        out  run ended without a unique survivor
//   iter_count out  number of update iterations performed
module maxnet_n #(
    parameter int unsigned N         = 4,
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned FRAC      = 4,
    parameter int unsigned EPS_SHIFT = 3,
    parameter int unsigned MAX_ITER  = 63,
    parameter int unsigned IDX_W     = $clog2(N),
    parameter int unsigned CNT_W     = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   x_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 tie,
    output logic [CNT_W-1:0]     iter_count
);

    // Headroom of clog2(N) bits keeps the activation sum from overflowing.
    localparam int unsigned AW = WIDTH + FRAC + $clog2(N);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e           state_q;
    logic [AW-1:0]    a_q    [N];
    logic [WIDTH-1:0] xreg_q [N];

    logic [AW-1:0]    sum;
    logic [AW-1:0]    inh    [N];
    logic [AW-1:0]    a_nxt  [N];
    logic [N-1:0]     nz_pre;
    logic [N-1:0]     nz_nxt;
    logic [N-1:0]     win_sel;
    logic             one_left;
    logic             none_left;
    logic [CNT_W-1:0] iter_next;
    logic             timeout;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_val;

    // One inhibition step on the current activations.
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = sum + a_q[i];
        end
        for (int i = 0; i < int'(N); i++) begin
            inh[i]    = (sum - a_q[i]) >> EPS_SHIFT;
            // Clamp at zero instead of going negative.
            a_nxt[i]  = (inh[i] >= a_q[i]) ? '0 : a_q[i] - inh[i];
            nz_nxt[i] = |a_nxt[i];
            nz_pre[i] = |a_q[i];
        end
    end

    always_comb begin
        none_left = (nz_nxt == '0);
        one_left  = !none_left && ((nz_nxt & (nz_nxt - N'(1))) == '0);
        iter_next = iter_count + CNT_W'(1);
        timeout   = (iter_next == CNT_W'(MAX_ITER));
        // If everything died this step, fall back to the pre-update survivors.
        win_sel   = none_left ? nz_pre : nz_nxt;
    end

    // Lowest-index set bit of win_sel, and the latched input at that index.
    always_comb begin
        win_idx = '0;
        win_val = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (win_sel[i]) begin
                win_idx = IDX_W'(i);
                win_val = xreg_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            winner_idx <= '0;
            tie        <= 1'b0;
            iter_count <= '0;
            for (int i = 0; i < int'(N); i++) begin
                a_q[i]    <= '0;
                xreg_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        iter_count <= '0;
                        for (int i = 0; i < int'(N); i++) begin
                            xreg_q[i] <= x_in[i*WIDTH +: WIDTH];
                            a_q[i]    <= AW'(x_in[i*WIDTH +: WIDTH]) << FRAC;
                        end
                        if (x_in == '0) begin
                            // Nothing to compete: report an immediate tie.
                            state_q    <= StDone;
                            done       <= 1'b1;
                            result     <= '0;
                            winner_idx <= '0;
                            tie        <= 1'b1;
                        end else begin
                            state_q <= StIter;
                            busy    <= 1'b1;
                        end
                    end
                end
                StIter: begin
                    for (int i = 0; i < int'(N); i++) begin
                        a_q[i] <= a_nxt[i];
                    end
                    iter_count <= iter_next;
                    if (one_left || none_left || timeout) begin
                        state_q    <= StDone;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        result     <= win_val;
                        winner_idx <= win_idx;
                        tie        <= !one_left;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_n.sv
module tb_maxnet_n;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start3;
    logic [19:0] x_in;

    logic        busy,  done,  tie;
    logic [4:0]  result;
    logic [1:0]  winner_idx;
    logic [5:0]  iter_count;

    logic        busy3, done3, tie3;
    logic [4:0]  result3;
    logic [1:0]  idx3;
    logic [1:0]  iter3;

    int errors = 0;
    int checks = 0;

    maxnet_n dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_in       (x_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .winner_idx (winner_idx),
        .tie        (tie),
        .iter_count (iter_count)
    );

    maxnet_n #(.MAX_ITER(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start3),
        .x_in       (x_in),
        .busy       (busy3),
        .done       (done3),
        .result     (result3),
        .winner_idx (idx3),
        .tie        (tie3),
        .iter_count (iter3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pack4(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [4:0] d);
        return {d, c, b, a};
    endfunction

    // Drive start for exactly one edge; returns #1 after the start edge.
    task automatic do_start(input logic [19:0] x);
        x_in  = x;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen, and busy samples.
    task automatic wait_done(input int limit, output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            if (busy === 1'b1) bcyc++;
            tick();
            cyc++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    int cyc, bcyc, npulse;
    logic busy_k9, busy_k10;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        x_in   = '0;
        tick();
        tick();
        check("rst_busy",   {31'd0, busy}, 0);
        check("rst_done",   {31'd0, done}, 0);
        check("rst_result", {27'd0, result}, 0);
        check("rst_idx",    {30'd0, winner_idx}, 0);
        check("rst_tie",    {31'd0, tie}, 0);
        check("rst_iter",   {26'd0, iter_count}, 0);
        rst = 1'b0;
        tick();

        // (1,2,3,4): channel 3 wins after 8 updates.
        do_start(pack4(5'd1, 5'd2, 5'd3, 5'd4));
        wait_done(200, cyc, bcyc);
        check("s1_cycles", cyc, 8);
        check("s1_busy_cycles", bcyc, 8);
        check("s1_result", {27'd0, result}, 4);
        check("s1_idx",    {30'd0, winner_idx}, 3);
        check("s1_tie",    {31'd0, tie}, 0);
        check("s1_iter",   {26'd0, iter_count}, 8);
        tick();
        check("s1_done_pulse", {31'd0, done}, 0);
        check("s1_hold_result", {27'd0, result}, 4);
        check("s1_hold_iter", {26'd0, iter_count}, 8);

        // (9,0,0,0): unique survivor after one update.
        do_start(pack4(5'd9, 5'd0, 5'd0, 5'd0));
        wait_done(200, cyc, bcyc);
        check("s2_cycles", cyc, 1);
        check("s2_result", {27'd0, result}, 9);
        check("s2_idx",    {30'd0, winner_idx}, 0);
        check("s2_tie",    {31'd0, tie}, 0);
        check("s2_iter",   {26'd0, iter_count}, 1);
        tick();

        // (5,5,2,0): the equal pair decays to 7 each and stalls; limit at 63.
        do_start(pack4(5'd5, 5'd5, 5'd2, 5'd0));
        wait_done(200, cyc, bcyc);
        check("s3_cycles", cyc, 63);
        check("s3_result", {27'd0, result}, 5);
        check("s3_idx",    {30'd0, winner_idx}, 0);
        check("s3_tie",    {31'd0, tie}, 1);
        check("s3_iter",   {26'd0, iter_count}, 63);
        tick();

        // All zero: done in the cycle right after the start edge.
        do_start(pack4(5'd0, 5'd0, 5'd0, 5'd0));
        wait_done(200, cyc, bcyc);
        check("s4_cycles", cyc, 0);
        check("s4_busy", {31'd0, busy}, 0);
        check("s4_result", {27'd0, result}, 0);
        check("s4_tie",    {31'd0, tie}, 1);
        check("s4_iter",   {26'd0, iter_count}, 0);
        tick();
        check("s4_done_pulse", {31'd0, done}, 0);

        // MAX_ITER=3 instance: forced stop with (0,0,20,42).
        x_in   = pack4(5'd1, 5'd2, 5'd3, 5'd4);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("s5_cycles", cyc, 3);
        check("s5_result", {27'd0, result3}, 3);
        check("s5_idx",    {30'd0, idx3}, 2);
        check("s5_tie",    {31'd0, tie3}, 1);
        check("s5_iter",   {30'd0, iter3}, 3);
        tick();

        // Reset during the 4th update of (1,2,3,4).
        do_start(pack4(5'd1, 5'd2, 5'd3, 5'd4));
        tick();
        check("s6_a0", {21'd0, dut.a_q[0]}, 0);
        check("s6_a1", {21'd0, dut.a_q[1]}, 16);
        check("s6_a2", {21'd0, dut.a_q[2]}, 34);
        check("s6_a3", {21'd0, dut.a_q[3]}, 52);
        tick();
        tick();
        check("s6_iter_mid", {26'd0, iter_count}, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_rst_busy",   {31'd0, busy}, 0);
        check("s6_rst_done",   {31'd0, done}, 0);
        check("s6_rst_result", {27'd0, result}, 0);
        check("s6_rst_tie",    {31'd0, tie}, 0);
        check("s6_rst_iter",   {26'd0, iter_count}, 0);
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) npulse++;
            tick();
        end
        check("s6_no_done", npulse, 0);
        do_start(pack4(5'd1, 5'd2, 5'd3, 5'd4));
        wait_done(200, cyc, bcyc);
        check("s6_cycles", cyc, 8);
        check("s6_result", {27'd0, result}, 4);
        check("s6_idx",    {30'd0, winner_idx}, 3);
        check("s6_tie",    {31'd0, tie}, 0);
        check("s6_iter",   {26'd0, iter_count}, 8);
        tick();
        tick();

        // start held high: one run per IDLE visit, reruns start 10 edges apart.
        x_in  = pack4(5'd1, 5'd2, 5'd3, 5'd4);
        start = 1'b1;
        tick();
        npulse   = 0;
        busy_k9  = 1'bx;
        busy_k10 = 1'bx;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (done === 1'b1) npulse++;
            if (k == 9)  busy_k9  = busy;
            if (k == 10) busy_k10 = busy;
        end
        check("s7_done_pulses", npulse, 2);
        check("s7_busy_idle",   {31'd0, busy_k9}, 0);
        check("s7_busy_rerun",  {31'd0, busy_k10}, 1);
        check("s7_iter",        {26'd0, iter_count}, 8);
        check("s7_result",      {27'd0, result}, 4);
        start = 1'b0;
        tick();
        tick();
        check("s7_released", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
